// File: rtl/address_generation_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : address_generation_unit_pkg
// Brief    : Shared opcode, access-size and FSM state definitions for the AGU.
// Revision : 1.0 - initial release
// ============================================================================
package address_generation_unit_pkg;

    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] c_SIZE_BYTE   = 2'd0;
    localparam logic [1:0] c_SIZE_HALF   = 2'd1;
    localparam logic [1:0] c_SIZE_WORD   = 2'd2;
    localparam logic [1:0] c_SIZE_DOUBLE = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT1 = 2'd1,
        ST_BEAT2 = 2'd2
    } agu_state_t;

    // Byte-lane mask of an access of the given size, before lane shifting.
    function automatic logic [7:0] size_mask(input logic [1:0] size);
        case (size)
            c_SIZE_BYTE: return 8'h01;
            c_SIZE_HALF: return 8'h03;
            c_SIZE_WORD: return 8'h0F;
            default:     return 8'hFF;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/address_generation_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : address_generation_unit_if
// Brief    : Request/result handshake bundle between an AGU and its neighbours.
// Revision : 1.0 - initial release
// ============================================================================
interface address_generation_unit_if #(
    parameter int XLEN = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [XLEN-1:0]   rs1;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   immediate;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   address;
    logic [XLEN/8-1:0] byte_enable;
    logic              beat_last;
    logic              misaligned;

    modport master (
        output in_valid, opcode, funct3, rs1, pc, immediate, out_ready,
        input  in_ready, out_valid, address, byte_enable, beat_last, misaligned
    );

    modport slave (
        input  in_valid, opcode, funct3, rs1, pc, immediate, out_ready,
        output in_ready, out_valid, address, byte_enable, beat_last, misaligned
    );
endinterface
`default_nettype wire

// File: rtl/address_generation_adder.sv
`default_nettype none
// ============================================================================
// Module   : address_generation_adder
// Brief    : XLEN-bit modular adder built from 4-bit carry-lookahead groups.
// Revision : 1.0 - initial release
// ============================================================================
module address_generation_adder #(
    parameter int XLEN = 32
) (
    input  wire logic [XLEN-1:0] i_a,
    input  wire logic [XLEN-1:0] i_b,
    output logic      [XLEN-1:0] o_sum
);
    localparam int c_GROUPS = XLEN / 4;

    logic [XLEN-1:0] w_g;
    logic [XLEN-1:0] w_p;
    logic [XLEN-1:0] w_c;

    assign w_g    = i_a & i_b;
    assign w_p    = i_a ^ i_b;
    assign w_c[0] = 1'b0;

    generate
        for (genvar gi = 0; gi < c_GROUPS; gi++) begin : g_cla
            localparam int c_B = gi * 4;
            assign w_c[c_B+1] = w_g[c_B] | (w_p[c_B] & w_c[c_B]);
            assign w_c[c_B+2] = w_g[c_B+1] | (w_p[c_B+1] & w_g[c_B])
                              | (w_p[c_B+1] & w_p[c_B] & w_c[c_B]);
            assign w_c[c_B+3] = w_g[c_B+2] | (w_p[c_B+2] & w_g[c_B+1])
                              | (w_p[c_B+2] & w_p[c_B+1] & w_g[c_B])
                              | (w_p[c_B+2] & w_p[c_B+1] & w_p[c_B] & w_c[c_B]);
            // Group carry-out feeds the next group; the final carry is discarded.
            if (gi < c_GROUPS - 1) begin : g_next
                assign w_c[c_B+4] = w_g[c_B+3] | (w_p[c_B+3] & w_g[c_B+2])
                                  | (w_p[c_B+3] & w_p[c_B+2] & w_g[c_B+1])
                                  | (w_p[c_B+3] & w_p[c_B+2] & w_p[c_B+1] & w_g[c_B])
                                  | (w_p[c_B+3] & w_p[c_B+2] & w_p[c_B+1] & w_p[c_B] & w_c[c_B]);
            end
        end
    endgenerate

    assign o_sum = w_p ^ w_c;
endmodule
`default_nettype wire

// File: rtl/address_generation_unit.sv
`default_nettype none
// ============================================================================
// Module   : address_generation_unit
// Brief    : Registered LOAD/STORE/control-flow address generator. Define
//            AGU_MISALIGNED_SPLIT_EN to split boundary-crossing accesses.
// Revision : 1.0 - initial release
// ============================================================================
module address_generation_unit
    import address_generation_unit_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int IALIGN = 32
) (
    input  wire logic             clk,
    input  wire logic             reset,
    address_generation_unit_if.slave bus
);
    localparam int c_BYTES = XLEN / 8;
    localparam int c_OFFW  = $clog2(c_BYTES);
    localparam int c_LW    = 2 * c_BYTES;

    agu_state_t r_state;
    agu_state_t w_state_nxt;

    logic [XLEN-1:0]    r_address;
    logic [c_BYTES-1:0] r_byte_enable;
    logic               r_beat_last;
    logic               r_misaligned;
    logic [XLEN-1:0]    r_addr2;
    logic [c_BYTES-1:0] r_be2;

    logic               w_is_ls;
    logic               w_is_ctrl;
    logic               w_is_jalr;
    logic               w_supported;
    logic [XLEN-1:0]    w_base;
    logic [XLEN-1:0]    w_sum_raw;
    logic [XLEN-1:0]    w_sum;
    logic [1:0]         w_size;
    logic [c_OFFW-1:0]  w_off;
    logic               w_size_ok;

    logic               w_ls_fault;
    logic               w_split;
    logic [XLEN-1:0]    w_ls_addr1;
    logic [c_BYTES-1:0] w_ls_be1;
    logic [XLEN-1:0]    w_addr2;
    logic [c_BYTES-1:0] w_be2;

    logic [XLEN-1:0]    w_addr1;
    logic [c_BYTES-1:0] w_be1;
    logic               w_last1;
    logic               w_mis1;

    logic               w_accept;
    logic               w_consume;
    logic               w_load;
    logic               w_advance;

    always_comb begin
        w_is_ls     = (bus.opcode == c_OP_LOAD) || (bus.opcode == c_OP_STORE);
        w_is_jalr   = (bus.opcode == c_OP_JALR);
        w_is_ctrl   = w_is_jalr || (bus.opcode == c_OP_JAL) || (bus.opcode == c_OP_BRANCH);
        w_supported = w_is_ls || w_is_ctrl || (bus.opcode == c_OP_AUIPC);
        w_base      = (w_is_ls || w_is_jalr) ? bus.rs1 : bus.pc;
    end

    address_generation_adder #(
        .XLEN (XLEN)
    ) u_adder (
        .i_a   (w_base),
        .i_b   (bus.immediate),
        .o_sum (w_sum_raw)
    );

    assign w_sum     = {w_sum_raw[XLEN-1:1], w_sum_raw[0] & ~w_is_jalr};
    assign w_size    = bus.funct3[1:0];
    assign w_off     = w_sum[c_OFFW-1:0];
    assign w_size_ok = (XLEN == 64) || (w_size != c_SIZE_DOUBLE);

`ifdef AGU_MISALIGNED_SPLIT_EN
    logic [c_LW-1:0]  w_lanes;
    logic [XLEN-1:0]  w_aligned_base;

    assign w_lanes        = c_LW'(size_mask(w_size)) << w_off;
    assign w_aligned_base = {w_sum[XLEN-1:c_OFFW], {c_OFFW{1'b0}}};
    // Lanes spilling past the word boundary go to the second beat.
    assign w_split        = w_size_ok && (|w_lanes[c_LW-1:c_BYTES]);
    assign w_ls_fault     = !w_size_ok;
    assign w_ls_addr1     = w_split ? w_aligned_base : w_sum;
    assign w_ls_be1       = w_lanes[c_BYTES-1:0];
    assign w_addr2        = w_aligned_base + XLEN'(c_BYTES);
    assign w_be2          = w_lanes[c_LW-1:c_BYTES];
`else
    logic [c_OFFW-1:0] w_align_mask;

    assign w_align_mask = c_OFFW'((8'd1 << w_size) - 8'd1);
    assign w_ls_fault   = !w_size_ok || (|(w_off & w_align_mask));
    assign w_split      = 1'b0;
    assign w_ls_addr1   = w_sum;
    assign w_ls_be1     = c_BYTES'(size_mask(w_size)) << w_off;
    assign w_addr2      = '0;
    assign w_be2        = '0;
`endif

    always_comb begin
        w_addr1 = w_sum;
        w_be1   = '0;
        w_last1 = 1'b1;
        w_mis1  = 1'b0;
        if (w_is_ls) begin
            if (w_ls_fault) begin
                w_mis1 = 1'b1;
            end else begin
                w_addr1 = w_ls_addr1;
                w_be1   = w_ls_be1;
                w_last1 = !w_split;
            end
        end else if (w_is_ctrl) begin
            w_mis1 = (IALIGN == 32) && w_sum[1];
        end
    end

    // Ready is forced low while reset is held so nothing is accepted then.
    assign bus.in_ready  = reset && ((r_state == ST_IDLE) ||
                           ((r_state == ST_BEAT1) && bus.out_ready && r_beat_last));
    assign bus.out_valid = (r_state != ST_IDLE);
    assign w_accept      = bus.in_valid && bus.in_ready;
    assign w_consume     = bus.out_valid && bus.out_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_advance   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && w_supported) begin
                    w_state_nxt = ST_BEAT1;
                    w_load      = 1'b1;
                end
            end
            ST_BEAT1: begin
                if (w_consume) begin
                    if (r_beat_last) begin
                        if (w_accept && w_supported) begin
                            w_state_nxt = ST_BEAT1;
                            w_load      = 1'b1;
                        end else begin
                            w_state_nxt = ST_IDLE;
                        end
                    end else begin
                        w_state_nxt = ST_BEAT2;
                        w_advance   = 1'b1;
                    end
                end
            end
            ST_BEAT2: begin
                if (w_consume) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_address     <= '0;
            r_byte_enable <= '0;
            r_beat_last   <= 1'b0;
            r_misaligned  <= 1'b0;
            r_addr2       <= '0;
            r_be2         <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_address     <= w_addr1;
                r_byte_enable <= w_be1;
                r_beat_last   <= w_last1;
                r_misaligned  <= w_mis1;
                r_addr2       <= w_addr2;
                r_be2         <= w_be2;
            end else if (w_advance) begin
                r_address     <= r_addr2;
                r_byte_enable <= r_be2;
                r_beat_last   <= 1'b1;
                r_misaligned  <= 1'b0;
            end
        end
    end

    assign bus.address     = r_address;
    assign bus.byte_enable = r_byte_enable;
    assign bus.beat_last   = r_beat_last;
    assign bus.misaligned  = r_misaligned;
endmodule
`default_nettype wire

// File: tb/tb_address_generation_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_address_generation_unit
// Brief    : Scoreboard bench for address_generation_unit at XLEN=32, IALIGN=32.
// Revision : 1.0 - initial release
// ============================================================================
module tb_address_generation_unit;
    import address_generation_unit_pkg::*;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        last;
        logic        mis;
    } beat_t;

    logic  clk   = 1'b0;
    logic  reset = 1'b0;
    int    total = 0;
    int    bad   = 0;
    int    cyc   = 0;
    beat_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    address_generation_unit_if #(.XLEN(32)) bus ();

    address_generation_unit #(
        .XLEN   (32),
        .IALIGN (32)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Expected beats for one accepted request.
    task automatic predict(input logic [6:0] op, input logic [2:0] f3,
                           input logic [31:0] rs1, input logic [31:0] pc, input logic [31:0] imm);
        beat_t       b;
        logic [31:0] s;
        logic [7:0]  lanes;
        int          nb;
        int          off;
        if (!(op inside {c_OP_LOAD, c_OP_STORE, c_OP_JALR, c_OP_JAL, c_OP_AUIPC, c_OP_BRANCH}))
            return;
        s = ((op == c_OP_LOAD || op == c_OP_STORE || op == c_OP_JALR) ? rs1 : pc) + imm;
        if (op == c_OP_JALR) s[0] = 1'b0;
        b.addr = s; b.be = 4'b0000; b.last = 1'b1; b.mis = 1'b0;
        if (op == c_OP_LOAD || op == c_OP_STORE) begin
            nb    = 1 << f3[1:0];
            off   = int'(s[1:0]);
            lanes = 8'(((1 << nb) - 1) << off);
            if (nb == 8) b.mis = 1'b1;
            else if (off % nb == 0) b.be = lanes[3:0];
            else begin
`ifdef AGU_MISALIGNED_SPLIT_EN
                if (off + nb > 4) begin
                    b.addr = {s[31:2], 2'b00}; b.be = lanes[3:0]; b.last = 1'b0;
                    sb.push_back(b);
                    b.addr = {s[31:2], 2'b00} + 32'd4; b.be = lanes[7:4]; b.last = 1'b1;
                end else begin
                    b.be = lanes[3:0];
                end
`else
                b.mis = 1'b1;
`endif
            end
        end else if (op != c_OP_AUIPC) begin
            b.mis = s[1];
        end
        sb.push_back(b);
    endtask

    always @(negedge clk) begin
        beat_t e;
        if (reset && bus.out_valid && bus.out_ready) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL beat_unexpected: got addr=%h be=%b last=%b mis=%b, required no beat",
                         bus.address, bus.byte_enable, bus.beat_last, bus.misaligned);
            end else begin
                e = sb.pop_front();
                if ({bus.address, bus.byte_enable, bus.beat_last, bus.misaligned} !==
                    {e.addr, e.be, e.last, e.mis}) begin
                    bad++;
                    $display("FAIL beat: got addr=%h be=%b last=%b mis=%b, required addr=%h be=%b last=%b mis=%b",
                             bus.address, bus.byte_enable, bus.beat_last, bus.misaligned,
                             e.addr, e.be, e.last, e.mis);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, required finish");
        $fatal(1, "watchdog");
    end

    // Present a request, wait for acceptance, return at posedge+1 after it.
    task automatic send(input logic [6:0] op, input logic [2:0] f3,
                        input logic [31:0] rs1, input logic [31:0] pc, input logic [31:0] imm);
        int n = 0;
        bus.in_valid = 1'b1; bus.opcode = op; bus.funct3 = f3;
        bus.rs1 = rs1; bus.pc = pc; bus.immediate = imm;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            total++; bad++;
            $display("FAIL accept_timeout: got in_ready=0, required 1");
        end
        predict(op, f3, rs1, pc, imm);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || bus.out_valid) && n < 200) begin
            bus.out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
            n++;
        end
        bus.out_ready = 1'b1;
        if (n >= 200) begin
            total++; bad++;
            $display("FAIL drain_timeout: got pending=%0d, required 0", sb.size());
        end
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0; bus.opcode = '0; bus.funct3 = '0;
        bus.rs1 = '0; bus.pc = '0; bus.immediate = '0; bus.out_ready = 1'b1;
        @(negedge clk);
        total++;
        if ({bus.out_valid, bus.in_ready, bus.address, bus.byte_enable, bus.beat_last, bus.misaligned} !== 40'd0) begin
            bad++;
            $display("FAIL reset_outputs: got valid=%b ready=%b addr=%h be=%b last=%b mis=%b, required all zero",
                     bus.out_valid, bus.in_ready, bus.address, bus.byte_enable, bus.beat_last, bus.misaligned);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        total++;
        if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
            bad++;
            $display("FAIL reset_release: got ready=%b valid=%b, required ready=1 valid=0",
                     bus.in_ready, bus.out_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_load();
        send(c_OP_LOAD, 3'd2, 32'h0000_1000, 32'h0, 32'hFFFF_FFFC);
        total++;
        if ({bus.out_valid, bus.address, bus.byte_enable, bus.misaligned} !== {1'b1, 32'h0000_0FFC, 4'b1111, 1'b0}) begin
            bad++;
            $display("FAIL load_latency: got valid=%b addr=%h be=%b mis=%b, required valid=1 addr=00000ffc be=1111 mis=0",
                     bus.out_valid, bus.address, bus.byte_enable, bus.misaligned);
        end
        drain();
    endtask

    task automatic test_control();
        send(c_OP_JALR, 3'd0, 32'h0000_2003, 32'h0, 32'h0);
        total++;
        if ({bus.address, bus.misaligned, bus.byte_enable, bus.beat_last} !== {32'h0000_2002, 1'b1, 4'b0000, 1'b1}) begin
            bad++;
            $display("FAIL jalr: got addr=%h mis=%b be=%b last=%b, required addr=00002002 mis=1 be=0000 last=1",
                     bus.address, bus.misaligned, bus.byte_enable, bus.beat_last);
        end
        drain();
        send(c_OP_AUIPC, 3'd0, 32'h0, 32'hFFFF_FFF0, 32'h0000_0020);
        total++;
        if ({bus.address, bus.misaligned} !== {32'h0000_0010, 1'b0}) begin
            bad++;
            $display("FAIL auipc_wrap: got addr=%h mis=%b, required addr=00000010 mis=0",
                     bus.address, bus.misaligned);
        end
        drain();
        send(c_OP_BRANCH, 3'd0, 32'hDEAD_BEEF, 32'h0000_0100, 32'h0000_0006);
        send(c_OP_JAL,    3'd0, 32'h0, 32'h0000_0100, 32'hFFFF_FFFC);
        send(c_OP_AUIPC,  3'd0, 32'h0, 32'h0000_0100, 32'h0000_0002);
        drain();
    endtask

    task automatic test_store_misaligned();
        send(c_OP_STORE, 3'd2, 32'h0000_1003, 32'h0, 32'h0);
`ifdef AGU_MISALIGNED_SPLIT_EN
        total++;
        if ({bus.address, bus.byte_enable, bus.beat_last, bus.in_ready} !== {32'h0000_1000, 4'b1000, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL split_beat1: got addr=%h be=%b last=%b ready=%b, required addr=00001000 be=1000 last=0 ready=0",
                     bus.address, bus.byte_enable, bus.beat_last, bus.in_ready);
        end
        @(posedge clk); #1;
        total++;
        if ({bus.address, bus.byte_enable, bus.beat_last, bus.in_ready} !== {32'h0000_1004, 4'b0111, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL split_beat2: got addr=%h be=%b last=%b ready=%b, required addr=00001004 be=0111 last=1 ready=0",
                     bus.address, bus.byte_enable, bus.beat_last, bus.in_ready);
        end
`else
        total++;
        if ({bus.byte_enable, bus.beat_last, bus.misaligned} !== {4'b0000, 1'b1, 1'b1}) begin
            bad++;
            $display("FAIL store_misaligned: got be=%b last=%b mis=%b, required be=0000 last=1 mis=1",
                     bus.byte_enable, bus.beat_last, bus.misaligned);
        end
`endif
        drain();
    endtask

    task automatic test_stall();
        bus.out_ready = 1'b0;
        send(c_OP_LOAD, 3'd1, 32'h0000_2000, 32'h0, 32'h0000_0002);
        bus.in_valid = 1'b1; bus.opcode = c_OP_STORE; bus.funct3 = 3'd0;
        bus.rs1 = 32'h0000_3000; bus.pc = 32'h0; bus.immediate = 32'h0000_0005;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if ({bus.out_valid, bus.address, bus.byte_enable, bus.beat_last, bus.misaligned, bus.in_ready} !==
                {1'b1, 32'h0000_2002, 4'b1100, 1'b1, 1'b0, 1'b0}) begin
                bad++;
                $display("FAIL stall_hold %0d: got valid=%b addr=%h be=%b last=%b mis=%b ready=%b, required 1 00002002 1100 1 0 0",
                         i, bus.out_valid, bus.address, bus.byte_enable, bus.beat_last, bus.misaligned, bus.in_ready);
            end
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL stall_release_ready: got %b, required 1", bus.in_ready);
        end
        predict(c_OP_STORE, 3'd0, 32'h0000_3000, 32'h0, 32'h0000_0005);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        total++;
        if ({bus.out_valid, bus.address, bus.byte_enable} !== {1'b1, 32'h0000_3005, 4'b0010}) begin
            bad++;
            $display("FAIL stall_next: got valid=%b addr=%h be=%b, required valid=1 addr=00003005 be=0010",
                     bus.out_valid, bus.address, bus.byte_enable);
        end
        drain();
    endtask

    task automatic test_unsupported();
        send(7'b0110011, 3'd2, 32'h0000_4000, 32'h0, 32'h4);
        total++;
        if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
            bad++;
            $display("FAIL unsupported: got valid=%b ready=%b, required valid=0 ready=1",
                     bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_back_to_back();
        int c0;
        bus.out_ready = 1'b1;
        c0 = cyc;
        send(c_OP_LOAD,  3'd2, 32'h0000_0100, 32'h0, 32'h0000_0004);
        send(c_OP_STORE, 3'd1, 32'h0000_0200, 32'h0, 32'h0000_0002);
        send(c_OP_JAL,   3'd0, 32'h0, 32'h0000_0400, 32'h0000_0010);
        send(c_OP_LOAD,  3'd0, 32'h0000_0300, 32'h0, 32'h0000_0003);
        send(c_OP_AUIPC, 3'd0, 32'h0, 32'h0001_0000, 32'h0000_1234);
        send(c_OP_STORE, 3'd2, 32'h0000_0500, 32'h0, 32'hFFFF_FFF8);
        total++;
        if ((cyc - c0) != 6) begin
            bad++;
            $display("FAIL back_to_back: got %0d cycles for 6 requests, required 6", cyc - c0);
        end
        drain();
    endtask

    task automatic test_random();
        logic [6:0] ops [6];
        ops = '{c_OP_LOAD, c_OP_STORE, c_OP_JALR, c_OP_JAL, c_OP_AUIPC, c_OP_BRANCH};
        for (int i = 0; i < 30; i++) begin
            send(ops[(i % 3 == 0) ? $urandom_range(2, 5) : $urandom_range(0, 1)],
                 3'($urandom_range(0, 7)), $urandom(), $urandom(), 32'($urandom_range(0, 15)) - 32'd8);
            drain();
        end
    endtask

    task automatic test_reset_mid();
`ifdef AGU_MISALIGNED_SPLIT_EN
        bus.out_ready = 1'b1;
        send(c_OP_STORE, 3'd2, 32'h0000_5002, 32'h0, 32'h0);
        @(posedge clk); #1;
`else
        bus.out_ready = 1'b0;
        send(c_OP_STORE, 3'd2, 32'h0000_5002, 32'h0, 32'h0);
`endif
        sb.delete();
        reset = 1'b0;
        #1;
        total++;
        if ({bus.out_valid, bus.in_ready} !== 2'b00) begin
            bad++;
            $display("FAIL reset_mid_async: got valid=%b ready=%b, required 0 0", bus.out_valid, bus.in_ready);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        total++;
        if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
            bad++;
            $display("FAIL reset_mid_release: got ready=%b valid=%b, required ready=1 valid=0",
                     bus.in_ready, bus.out_valid);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if (bus.out_valid !== 1'b0) begin
                bad++;
                $display("FAIL reset_mid_no_beat %0d: got valid=%b, required 0", i, bus.out_valid);
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_load();
        test_control();
        test_store_misaligned();
        test_stall();
        test_unsupported();
        test_back_to_back();
        test_random();
        test_reset_mid();
        drain();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL leftover_beats: got %0d pending, required 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
